// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache for the MEM stage.
// Hits complete in zero cycles; misses stall the pipeline while lines are evicted/refilled.
module dcache_ctrl #(
    parameter int ADDR_W = 32,
    parameter int LINES  = 16,
    parameter int LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam int INDEX_W = $clog2(LINES);
    localparam int TAG_W   = ADDR_W - INDEX_W - 5;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_ALLOC, S_REFILL} state_t;

    state_t state_q, state_d;

    logic [LINE_W-1:0] line_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word;
    logic [7:0]         woff;
    logic               hit;
    logic               store_hit;
    logic               fill_done;
    logic               unused_addr_bits;

    assign idx  = cpu_addr_i[4+INDEX_W:5];
    assign tag  = cpu_addr_i[ADDR_W-1:5+INDEX_W];
    assign word = cpu_addr_i[4:2];
    assign woff = {word, 5'b0};
    assign unused_addr_bits = ^cpu_addr_i[1:0];

    assign hit       = valid_q[idx] & (tag_q[idx] == tag);
    assign store_hit = cpu_req_i & cpu_we_i & hit & (state_q == S_IDLE);
    assign fill_done = (state_q == S_ALLOC) & mem_ack_i;

    // Held low during reset so a frozen pipeline is released immediately.
    assign cpu_stall_o = rst_i & cpu_req_i & (~hit | (state_q != S_IDLE));
    assign cpu_rdata_o = line_q[idx][woff +: 32];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            S_IDLE: begin
                if (cpu_req_i && !hit) begin
                    state_d = dirty_q[idx] ? S_WB : S_ALLOC;
                end
            end
            S_WB: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_addr_o  = {tag_q[idx], idx, 5'b0};
                mem_wdata_o = line_q[idx];
                if (mem_ack_i) state_d = S_ALLOC;
            end
            S_ALLOC: begin
                mem_en_o   = 1'b1;
                mem_addr_o = {tag, idx, 5'b0};
                if (mem_ack_i) state_d = S_REFILL;
            end
            S_REFILL: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Line data and tags carry no reset; validity alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (fill_done) begin
            line_q[idx] <= mem_rdata_i;
            tag_q[idx]  <= tag;
        end else if (store_hit) begin
            line_q[idx][woff +: 32] <= cpu_wdata_i;
        end
    end

endmodule
